sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
- Downstream consumer of the clock divider's `sclk` output.
- Drives a 4-digit, common-anode, multiplexed seven-segment display from a 14-bit binary value.
- Converts the accepted value to BCD with a sequential double-dabble FSM.
- Advances the digit scan once per rising edge of `sclk`. `sclk` is sampled as a data signal in the `clk` domain and is never used as a clock.

Parameters:
- BLANK_LZ, 1: 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all four digits.
- MAX_VAL, 9999: saturation limit applied to `value` at accept.

Ports:
- clk    input   1   system clock; the single clock of the block.
- rst_n  input   1   synchronous, active-low reset.
- sclk   input   1   divided scan clock from the divider; treated as data and edge-detected.
- load   input   1   request to display `value`.
- value  input   14  unsigned binary value to display.
- ready  output  1   high = block can accept a load.
- an     output  4   digit anodes, active-low; an[0] is the rightmost digit.
- seg    output  8   cathodes, active-low, ordered {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst_n=0 sampled on a clk edge):
  - state=IDLE, digit index idx=0, disp_bcd=16'h0000, sclk_q=0, ready=1.
  - Outputs: an=4'b1110, seg=8'hC0 (shows "0").
  - Reset asserted mid-conversion aborts the conversion; no partial result reaches disp_bcd.
- Edge detect:
  - sclk_q <= sclk every cycle.
  - tick = sclk & ~sclk_q.
  - Exactly one tick per sclk rising edge, regardless of how long sclk stays high.
- Accept:
  - A load is accepted on the clk edge where load=1 and ready=1.
  - On accept, capture min(value, MAX_VAL); this clamps 10000–16383 to 9999.
  - load while ready=0 is ignored; the request is not queued.
- Conversion FSM:
  - IDLE: ready=1. On accept, load the shift register {16'b0, captured value}, set iteration counter=0, and go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is >=5, then shift the whole register left by 1 bit.
    - This takes 14 cycles; the counter runs 0..13.
    - After the iteration with counter=13, go to DONE.
  - DONE: copy the 16-bit BCD result to disp_bcd and go to IDLE.
- Latency and handshake:
  - ready is low for exactly 15 cycles after the accepting edge.
  - disp_bcd updates on the 15th edge after accept.
  - ready is high again after that edge, so back-to-back loads are accepted every 16 cycles.
- Scanner:
  - Runs independently of the FSM.
  - On each clk edge with tick=1, idx <= idx+1, wrapping 3 -> 0.
  - an = ~(4'b0001 << idx).
- Segment decode:
  - Combinational from the registered idx and disp_bcd.
  - Active-low codes for digits 0–9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Nibble values above 9 cannot occur; if one does, decode it as blank (FF).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k>0 is blanked (seg=8'hFF) when nibbles k..3 are all zero.
- Simultaneous events:
  - A tick during conversion still advances idx, using the old disp_bcd.
  - On the DONE edge with a tick, idx advances and the new disp_bcd applies from the next cycle.
- Decimal point: without the optional feature, seg[7]=1 always.

Optional Feature:
- Macro: SSEG_DP_EN.
- Defined:
  - Adds port `dp`, input, 4 bits; dp[k] lights the decimal point of digit k.
  - `dp` is captured together with `value` at accept and applied at the DONE edge.
  - seg[7] = ~dp_reg[idx]. A blanked digit with dp set shows only its dp (8'h7F).
  - Reset value of dp_reg = 0.
- Undefined: no `dp` port; seg[7] is held at 1.

Test Plan:
- Reset: rst_n=0 for 3 clk cycles, then 1; hold sclk=0 -> an=4'b1110, seg=8'hC0, ready=1, and idx does not move.
- Load 1234 with BLANK_LZ=1:
  - ready is low for exactly 15 cycles.
  - Then 4 sclk rising edges give an 1101/1011/0111/1110 with seg B0/A4/F9/99 respectively (digit0 shows 4).
- Load 12000 -> clamped to 9999; all four digits show 8'h90.
- Load 7, then load 0 (BLANK_LZ=1):
  - After the first load: digit0=F8, digits1–3=FF.
  - After the second load: digit0=C0, others FF.
  - With BLANK_LZ=0, loading 7 gives C0 on digits1–3.
- Handshake and reset:
  - Pulse load=1 with value=55 five cycles into a conversion -> ignored; display keeps the first value.
  - Assert rst_n=0 during SHIFT -> disp_bcd=0 and seg=C0 on digit0.
- Edge detect: hold sclk=1 for 50 clk cycles -> idx advances exactly once; sclk toggling every 2200 clk cycles gives one advance per rising edge. With SSEG_DP_EN, dp=4'b0100 with value 1234 -> digit2 shows 8'h24.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit common-anode multiplexed seven-segment driver.
// Accepts a 14-bit value and clamps it to MAX_VAL. A sequential double-dabble
// converts it to BCD, and the digits are scanned on rising edges of sclk.
// sclk is sampled as data in the clk domain.
// Optional macro SSEG_DP_EN adds a 4-bit per-digit decimal point input `dp`.
module sseg_scan_ctrl #(
  parameter int unsigned BLANK_LZ = 1,
  parameter int unsigned MAX_VAL  = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        load,
  input  logic [13:0] value,
`ifdef SSEG_DP_EN
  input  logic [3:0]  dp,
`endif
  output logic        ready,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned VAL_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SR_W   = BCD_W + VAL_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NIB_N  = 4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VAL_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sclk_q, sclk_d;
`ifdef SSEG_DP_EN
  logic [3:0]       dp_pend_q, dp_pend_d;
  logic [3:0]       dp_reg_q, dp_reg_d;
`endif

  logic             tick_c;
  logic             accept_c;
  logic [VAL_W-1:0] val_clamped_c;
  logic [SR_W-1:0]  sr_adj_c;
  logic [3:0]       nib_c;
  logic             blank_c;
  logic [6:0]       code_c;
  logic             dp_bit_c;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      disp_bcd_q <= '0;
      idx_q      <= '0;
      sclk_q     <= 1'b0;
`ifdef SSEG_DP_EN
      dp_pend_q  <= '0;
      dp_reg_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      disp_bcd_q <= disp_bcd_d;
      idx_q      <= idx_d;
      sclk_q     <= sclk_d;
`ifdef SSEG_DP_EN
      dp_pend_q  <= dp_pend_d;
      dp_reg_q   <= dp_reg_d;
`endif
    end
  end

  // Input clamp and add-3 correction of every BCD nibble ahead of the shift.
  always_comb begin
    val_clamped_c = value;
    if (32'(value) > MAX_VAL) begin
      val_clamped_c = VAL_W'(MAX_VAL);
    end
    sr_adj_c = sr_q;
    for (int i = 0; i < int'(NIB_N); i++) begin
      if (sr_q[VAL_W + 4*i +: 4] >= 4'd5) begin
        sr_adj_c[VAL_W + 4*i +: 4] = sr_q[VAL_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: sclk edge detect, scan index and conversion FSM.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    disp_bcd_d = disp_bcd_q;
    sclk_d     = sclk;
`ifdef SSEG_DP_EN
    dp_pend_d  = dp_pend_q;
    dp_reg_d   = dp_reg_q;
`endif

    tick_c   = sclk & ~sclk_q;
    idx_d    = tick_c ? IDX_W'(idx_q + IDX_W'(1)) : idx_q;
    accept_c = load & (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          sr_d    = {BCD_W'(0), val_clamped_c};
          cnt_d   = '0;
          state_d = ST_SHIFT;
`ifdef SSEG_DP_EN
          dp_pend_d = dp;
`endif
        end
      end
      ST_SHIFT: begin
        sr_d  = {sr_adj_c[SR_W-2:0], 1'b0};
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        disp_bcd_d = sr_q[SR_W-1:VAL_W];
`ifdef SSEG_DP_EN
        dp_reg_d   = dp_pend_q;
`endif
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Digit select, leading-zero blanking and active-low segment decode.
  always_comb begin
    nib_c   = disp_bcd_q[3:0];
    blank_c = 1'b0;
    case (idx_q)
      2'd0: begin
        nib_c   = disp_bcd_q[3:0];
        blank_c = 1'b0;
      end
      2'd1: begin
        nib_c   = disp_bcd_q[7:4];
        blank_c = (disp_bcd_q[15:4] == 12'h000);
      end
      2'd2: begin
        nib_c   = disp_bcd_q[11:8];
        blank_c = (disp_bcd_q[15:8] == 8'h00);
      end
      default: begin
        nib_c   = disp_bcd_q[15:12];
        blank_c = (disp_bcd_q[15:12] == 4'h0);
      end
    endcase
    if (BLANK_LZ == 0) begin
      blank_c = 1'b0;
    end

    case (nib_c)
      4'd0:    code_c = 7'h40;
      4'd1:    code_c = 7'h79;
      4'd2:    code_c = 7'h24;
      4'd3:    code_c = 7'h30;
      4'd4:    code_c = 7'h19;
      4'd5:    code_c = 7'h12;
      4'd6:    code_c = 7'h02;
      4'd7:    code_c = 7'h78;
      4'd8:    code_c = 7'h00;
      4'd9:    code_c = 7'h10;
      default: code_c = 7'h7F;
    endcase
    if (blank_c) begin
      code_c = 7'h7F;
    end

`ifdef SSEG_DP_EN
    dp_bit_c = ~dp_reg_q[idx_q];
`else
    dp_bit_c = 1'b1;
`endif
  end

  // Outputs derive directly from registered state.
  assign ready = (state_q == ST_IDLE);
  assign an    = ~(4'b0001 << idx_q);
  assign seg   = {dp_bit_c, code_c};

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: two instances (leading-zero blanking on
// and off) share stimulus; a monitor checks each scan step and each busy window.
module tb_sseg_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] s0;
    logic [7:0] s1;
  } scan_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic [3:0]  dp = '0;
  logic        ready0, ready1;
  logic [3:0]  an0, an1;
  logic [7:0]  seg0, seg1;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  scan_t scan_q[$];
  int    ready_q[$];
  logic [3:0] prev_an = 4'b1110;
  int    low_cnt = 0;
  logic [3:0] an_seq [4];

  sseg_scan_ctrl #(.BLANK_LZ(1), .MAX_VAL(9999)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .load(load), .value(value),
`ifdef SSEG_DP_EN
    .dp(dp),
`endif
    .ready(ready0), .an(an0), .seg(seg0));

  sseg_scan_ctrl #(.BLANK_LZ(0), .MAX_VAL(9999)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .load(load), .value(value),
`ifdef SSEG_DP_EN
    .dp(dp),
`endif
    .ready(ready1), .an(an1), .seg(seg1));

  always #5 clk = ~clk;

  // Monitor: a change of the anodes pops a scan expectation; the end of a
  // busy window pops the expected ready-low length (0 = not checked).
  always @(negedge clk) begin
    scan_t e;
    int    exp_len;
    if (mon_en) begin
      if (an0 !== prev_an) begin
        checks++;
        if (scan_q.size() == 0) begin
          errors++;
          $display("FAIL scan_unexpected an=%b seg0=%h seg1=%h", an0, seg0, seg1);
        end else begin
          e = scan_q.pop_front();
          if (an0 !== e.an || an1 !== e.an || seg0 !== e.s0 || seg1 !== e.s1) begin
            errors++;
            $display("FAIL scan got an=%b/%b seg0=%h seg1=%h want an=%b seg0=%h seg1=%h",
                     an0, an1, seg0, seg1, e.an, e.s0, e.s1);
          end
        end
      end
      if (ready0 !== 1'b1) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        if (ready_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready_unexpected low for %0d cycles", low_cnt);
        end else begin
          exp_len = ready_q.pop_front();
          if (exp_len != 0) begin
            checks++;
            if (low_cnt != exp_len) begin
              errors++;
              $display("FAIL ready_low got %0d cycles want %0d", low_cnt, exp_len);
            end
          end
        end
        low_cnt = 0;
      end
    end
    prev_an = an0;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (ready0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready0 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got %b want 1", ready0);
    end
  endtask

  task automatic start_load(input logic [13:0] v, input logic [3:0] d, input int exp_len);
    wait_ready();
    ready_q.push_back(exp_len);
    load  = 1'b1;
    value = v;
    dp    = d;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic tick(input int hold);
    @(negedge clk);
    sclk = 1'b1;
    repeat (hold) @(negedge clk);
    sclk = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  // Expected bytes packed as {idx1, idx2, idx3, idx0}.
  task automatic scan4(input logic [31:0] t0, input logic [31:0] t1);
    for (int i = 0; i < 4; i++) begin
      scan_q.push_back('{an: an_seq[i], s0: t0[31-8*i -: 8], s1: t1[31-8*i -: 8]});
    end
    for (int i = 0; i < 4; i++) tick(3);
  endtask

  task automatic load_scan(input logic [13:0] v, input logic [31:0] t0, input logic [31:0] t1);
    start_load(v, 4'b0000, 15);
    wait_ready();
    scan4(t0, t1);
  endtask

  initial begin
    an_seq[0] = 4'b1101;
    an_seq[1] = 4'b1011;
    an_seq[2] = 4'b0111;
    an_seq[3] = 4'b1110;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_an", {4'h0, an0}, 8'h0E);
    chk("reset_seg0", seg0, 8'hC0);
    chk("reset_seg1", seg1, 8'hC0);
    chk("reset_ready", {7'h0, ready0}, 8'h01);
    repeat (5) @(negedge clk);
    chk("idle_an", {4'h0, an0}, 8'h0E);
    prev_an = an0;
    mon_en  = 1'b1;

    load_scan(14'd1234,  32'hB0A4F999, 32'hB0A4F999);
    load_scan(14'd12000, 32'h90909090, 32'h90909090);
    load_scan(14'd16383, 32'h90909090, 32'h90909090);
    load_scan(14'd7,     32'hFFFFFFF8, 32'hC0C0C0F8);
    load_scan(14'd0,     32'hFFFFFFC0, 32'hC0C0C0C0);

    // Load during conversion is dropped.
    start_load(14'd1234, 4'b0000, 15);
    repeat (5) @(negedge clk);
    load  = 1'b1;
    value = 14'd55;
    @(negedge clk);
    load  = 1'b0;
    wait_ready();
    scan4(32'hB0A4F999, 32'hB0A4F999);

    // Reset in the middle of SHIFT discards the conversion.
    start_load(14'd7, 4'b0000, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_an", {4'h0, an0}, 8'h0E);
    chk("abort_seg0", seg0, 8'hC0);
    chk("abort_seg1", seg1, 8'hC0);
    chk("abort_ready", {7'h0, ready0}, 8'h01);
    scan4(32'hFFFFFFC0, 32'hC0C0C0C0);

    // Long-high sclk gives one advance; slow toggling one per rising edge.
    scan_q.push_back('{an: 4'b1101, s0: 8'hFF, s1: 8'hC0});
    tick(50);
    scan_q.push_back('{an: 4'b1011, s0: 8'hFF, s1: 8'hC0});
    scan_q.push_back('{an: 4'b0111, s0: 8'hFF, s1: 8'hC0});
    scan_q.push_back('{an: 4'b1110, s0: 8'hC0, s1: 8'hC0});
    for (int i = 0; i < 3; i++) tick(2200);

    // A tick during conversion uses the old display contents.
    start_load(14'd1234, 4'b0000, 15);
    scan_q.push_back('{an: 4'b1101, s0: 8'hFF, s1: 8'hC0});
    tick(2);
    wait_ready();
    scan_q.push_back('{an: 4'b1011, s0: 8'hA4, s1: 8'hA4});
    scan_q.push_back('{an: 4'b0111, s0: 8'hF9, s1: 8'hF9});
    scan_q.push_back('{an: 4'b1110, s0: 8'h99, s1: 8'h99});
    for (int i = 0; i < 3; i++) tick(3);

`ifdef SSEG_DP_EN
    start_load(14'd1234, 4'b0100, 15);
    wait_ready();
    scan4(32'hB024F999, 32'hB024F999);
`endif

    repeat (10) @(negedge clk);
    checks++;
    if (scan_q.size() != 0 || ready_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got scan=%0d ready=%0d want 0", scan_q.size(), ready_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
